// File: rtl/dcsk_chip_serializer.sv
`default_nettype none
// ============================================================================
// Module   : dcsk_chip_serializer
// Brief    : Turns one expanded chaos word plus one data bit into a serial
//            DCSK symbol: CHIP_LEN reference chips followed by CHIP_LEN
//            information chips (reference, inverted when the bit is 0).
//            Each chip is held for SPC output samples.
// Revision : 1.0 - initial release
// ============================================================================
module dcsk_chip_serializer #(
    parameter int CHIP_LEN = 256,
    parameter int SPC      = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CHIP_LEN-1:0] i_chaos,
    input  logic                i_bit,
    input  logic                i_valid,
    output logic                o_ready,
    output logic                o_chip,
    output logic                o_chip_valid,
    input  logic                i_chip_ready,
    output logic                o_sym_start,
    output logic                o_sym_last
);

    localparam int c_IDX_W  = $clog2(CHIP_LEN);
    localparam int c_SAMP_W = (SPC > 1) ? $clog2(SPC) : 1;

    localparam logic [c_IDX_W-1:0]  c_IDX_MAX  = c_IDX_W'(CHIP_LEN - 1);
    localparam logic [c_SAMP_W-1:0] c_SAMP_MAX = c_SAMP_W'(SPC - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REF  = 2'd1;
    localparam logic [1:0] c_ST_INFO = 2'd2;

    logic [1:0]          r_state;
    logic [CHIP_LEN-1:0] r_ref;
    logic                r_bit;
    logic [c_IDX_W-1:0]  r_chip_idx;
    logic [c_SAMP_W-1:0] w_samp_cnt;

    logic w_out_xfer;
    logic w_in_xfer;
    logic w_last_samp;
    logic w_last_chip;

    assign w_out_xfer  = o_chip_valid && i_chip_ready;
    assign w_in_xfer   = i_valid && o_ready;
    assign w_last_samp = (w_samp_cnt == c_SAMP_MAX);
    assign w_last_chip = (r_chip_idx == c_IDX_MAX) && w_last_samp;

    // Sample-hold counter; collapses to a constant when each chip is one sample.
    generate
        if (SPC == 1) begin : g_spc_one
            assign w_samp_cnt = '0;
        end else begin : g_spc_multi
            logic [c_SAMP_W-1:0] r_samp_cnt;

            // Advance per accepted sample, wrapping at the end of each chip.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_samp_cnt <= '0;
                end else if (r_state == c_ST_IDLE) begin
                    r_samp_cnt <= '0;
                end else if (w_out_xfer) begin
                    r_samp_cnt <= w_last_samp ? '0 : r_samp_cnt + c_SAMP_W'(1);
                end
            end

            assign w_samp_cnt = r_samp_cnt;
        end
    endgenerate

    // Chip index advances when a chip's last sample is accepted; wraps per half.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chip_idx <= '0;
        end else if (r_state == c_ST_IDLE) begin
            r_chip_idx <= '0;
        end else if (w_out_xfer && w_last_samp) begin
            r_chip_idx <= (r_chip_idx == c_IDX_MAX) ? '0 : r_chip_idx + c_IDX_W'(1);
        end
    end

    // Symbol sequencing and capture of the reference word and data bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_ST_IDLE;
            r_ref   <= '0;
            r_bit   <= 1'b0;
        end else begin
            // Any accepted input starts a new symbol; o_ready already restricts
            // this to IDLE or the final accepted info sample.
            if (w_in_xfer) begin
                r_ref <= i_chaos;
                r_bit <= i_bit;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_in_xfer) begin
                        r_state <= c_ST_REF;
                    end
                end
                c_ST_REF: begin
                    if (w_out_xfer && w_last_chip) begin
                        r_state <= c_ST_INFO;
                    end
                end
                c_ST_INFO: begin
                    if (w_out_xfer && w_last_chip) begin
                        r_state <= w_in_xfer ? c_ST_REF : c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Chip value and framing flags decode directly from registered state.
    always_comb begin
        o_chip       = 1'b0;
        o_chip_valid = 1'b0;
        o_sym_start  = 1'b0;
        o_sym_last   = 1'b0;
        case (r_state)
            c_ST_REF: begin
                o_chip_valid = 1'b1;
                o_chip       = r_ref[r_chip_idx];
                o_sym_start  = (r_chip_idx == '0) && (w_samp_cnt == '0);
            end
            c_ST_INFO: begin
                o_chip_valid = 1'b1;
                o_chip       = ~(r_ref[r_chip_idx] ^ r_bit);
                o_sym_last   = w_last_chip;
            end
            default: begin
                o_chip_valid = 1'b0;
            end
        endcase
    end

    // Accept a new symbol when idle, or exactly as the final sample leaves.
    always_comb begin
        o_ready = (r_state == c_ST_IDLE) ||
                  ((r_state == c_ST_INFO) && w_last_chip && i_chip_ready);
    end

endmodule
`default_nettype wire

// File: tb/tb_dcsk_chip_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcsk_chip_serializer
// Brief    : Scoreboard bench for dcsk_chip_serializer (SPC=1 and SPC=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcsk_chip_serializer;

    localparam int CL = 256;

    typedef struct packed {
        logic chip;
        logic start;
        logic last;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [CL-1:0] chaos;
    logic          bit_in;
    logic          valid0, valid1;
    logic          cready;
    logic          rdy0, chip0, cval0, st0, la0;
    logic          rdy1, chip1, cval1, st1, la1;

    exp_t q0[$];
    exp_t q1[$];
    int   checks;
    int   errors;
    int   pops0, pops1;
    int   run_len, last_run;
    logic rand_mode;

    dcsk_chip_serializer #(.CHIP_LEN(CL), .SPC(1)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_chaos(chaos), .i_bit(bit_in),
        .i_valid(valid0), .o_ready(rdy0), .o_chip(chip0),
        .o_chip_valid(cval0), .i_chip_ready(cready),
        .o_sym_start(st0), .o_sym_last(la0)
    );

    dcsk_chip_serializer #(.CHIP_LEN(CL), .SPC(4)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_chaos(chaos), .i_bit(bit_in),
        .i_valid(valid1), .o_ready(rdy1), .o_chip(chip1),
        .o_chip_valid(cval1), .i_chip_ready(cready),
        .o_sym_start(st1), .o_sym_last(la1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream ready: constant high, or a coin flip per cycle in stall mode.
    initial begin
        cready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Expected sample stream for one symbol.
    function automatic void push_symbol(input int d, input logic [CL-1:0] ch,
                                        input logic b, input int spc);
        exp_t e;
        for (int i = 0; i < 2 * CL; i++) begin
            for (int s = 0; s < spc; s++) begin
                e.chip  = (i < CL) ? ch[i] : ~(ch[i-CL] ^ b);
                e.start = (i == 0) && (s == 0);
                e.last  = (i == 2 * CL - 1) && (s == spc - 1);
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Compare one DUT's presented output against the head of its queue.
    task automatic mon(input int d, input logic v, input logic ch, input logic st,
                       input logic la, input logic rdy);
        exp_t e;
        int   qs;
        qs = (d == 0) ? q0.size() : q1.size();
        if (v === 1'b1) begin
            if (qs == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid dut%0d: got valid=1 want 0", d);
            end else begin
                e = (d == 0) ? q0[0] : q1[0];
                checks++;
                if ({ch, st, la} !== {e.chip, e.start, e.last}) begin
                    errors++;
                    $display("FAIL sample dut%0d #%0d: got chip/start/last=%b%b%b want %b%b%b",
                             d, (d == 0) ? pops0 : pops1, ch, st, la, e.chip, e.start, e.last);
                end
                checks++;
                if (rdy !== (e.last && cready)) begin
                    errors++;
                    $display("FAIL busy_ready dut%0d: got %b want %b", d, rdy, e.last && cready);
                end
                if (cready) begin
                    if (d == 0) begin void'(q0.pop_front()); pops0++; end
                    else        begin void'(q1.pop_front()); pops1++; end
                end
            end
        end else if (rst === 1'b0) begin
            checks++;
            if (qs != 0) begin
                errors++;
                $display("FAIL missing_sample dut%0d: got valid=%b want 1", d, v);
            end
            checks++;
            if (rdy !== 1'b1) begin
                errors++;
                $display("FAIL idle_ready dut%0d: got %b want 1", d, rdy);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            mon(0, cval0, chip0, st0, la0, rdy0);
            mon(1, cval1, chip1, st1, la1, rdy1);
            if (cval0 === 1'b1) begin
                run_len++;
            end else begin
                if (run_len > 0) last_run = run_len;
                run_len = 0;
            end
        end
    end

    task automatic send(input int d, input logic [CL-1:0] ch, input logic b);
        logic ok;
        chaos  = ch;
        bit_in = b;
        if (d == 0) valid0 = 1'b1;
        else        valid1 = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 20000 && !ok; n++) begin
            @(negedge clk);
            if (((d == 0) ? rdy0 : rdy1) === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout dut%0d: got ready=0 want 1", d);
        end
        @(posedge clk);
        #1;
        if (ok) push_symbol(d, ch, b, (d == 0) ? 1 : 4);
        if (d == 0) valid0 = 1'b0;
        else        valid1 = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 20000 && !ok; n++) begin
            @(posedge clk);
            if (((d == 0) ? q0.size() : q1.size()) == 0) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout dut%0d: got pending>0 want 0", d);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [CL-1:0] a5;
        logic          ok;
        checks    = 0;
        errors    = 0;
        pops0     = 0;
        pops1     = 0;
        run_len   = 0;
        last_run  = 0;
        rand_mode = 1'b0;
        rst       = 1'b1;
        valid0    = 1'b0;
        valid1    = 1'b0;
        chaos     = '0;
        bit_in    = 1'b0;
        for (int i = 0; i < CL / 8; i++) a5[i*8 +: 8] = 8'hA5;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_dut0", {cval0, chip0, st0, la0}, 4'b0000);
        check("reset_ready0", {3'b000, rdy0}, 4'b0001);
        check("reset_dut1", {cval1, chip1, st1, la1}, 4'b0000);
        check("reset_ready1", {3'b000, rdy1}, 4'b0001);
        @(posedge clk);
        #1;

        // Single symbols, both data polarities.
        send(0, 256'h1, 1'b1);
        wait_idle(0);
        send(0, 256'h1, 1'b0);
        wait_idle(0);

        // Back-to-back: B is held valid while A is still streaming.
        send(0, 256'h1, 1'b1);
        send(0, 256'h1, 1'b0);
        wait_idle(0);
        check("gapless_run_hi", {2'b00, last_run[11:10]}, 4'b0001);
        check("gapless_run_lo", {last_run[9:8] != 2'b00, 3'b000} | {1'b0, last_run[7:5] != 3'b000, 2'b00}, 4'b0000);

        // Random downstream stalls.
        rand_mode = 1'b1;
        send(0, a5, 1'b1);
        wait_idle(0);
        rand_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Four samples per chip.
        send(1, 256'h3, 1'b0);
        wait_idle(1);

        // Reset mid-reference at chip 100, with a competing input present.
        send(0, a5, 1'b1);
        ok = 1'b0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(posedge clk);
            #2;
            if (q0.size() == 2 * CL - 100) ok = 1'b1;
        end
        check("reach_chip100", {3'b000, ok}, 4'b0001);
        rst    = 1'b1;
        valid0 = 1'b1;
        chaos  = '1;
        bit_in = 1'b1;
        @(posedge clk);
        #1;
        q0.delete();
        rst    = 1'b0;
        valid0 = 1'b0;
        @(negedge clk);
        check("abort_valid", {3'b000, cval0}, 4'b0000);
        check("abort_ready", {3'b000, rdy0}, 4'b0001);
        @(posedge clk);
        #1;
        send(0, 256'h5, 1'b1);
        wait_idle(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
